// File: rtl/lbp_host_mem.sv
// Host-side memory responder for the LBP engine: holds the gray image, serves reads,
// captures and audits result writes, and reports completion and error flags.
module lbp_host_mem #(
  parameter int unsigned IMG_W  = 128,
  parameter int unsigned IMG_H  = 128,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic              gray_ready,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_count,
  output logic              done,
  output logic              err_border,
  output logic              err_dup,
  output logic              err_early
);

  localparam int unsigned NumPix   = IMG_W * IMG_H;
  localparam int unsigned ColW     = $clog2(IMG_W);
  localparam int unsigned RowW     = ADDR_W - ColW;
  localparam int unsigned Interior = (IMG_W - 2) * (IMG_H - 2);

  localparam logic [ADDR_W-1:0] LastPix     = ADDR_W'(NumPix - 1);
  localparam logic [ADDR_W:0]   InteriorCnt = (ADDR_W + 1)'(Interior);
  localparam logic [RowW-1:0]   RowLast     = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0]   ColLast     = ColW'(IMG_W - 1);

  typedef enum logic [1:0] {StLoad, StServe, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   wr_count_q, wr_count_d;
  logic                gray_ready_q, gray_ready_d;
  logic                done_q, done_d;
  logic                err_border_q, err_border_d;
  logic                err_dup_q, err_dup_d;
  logic                err_early_q, err_early_d;

  logic [DATA_W-1:0]   gray_mem [NumPix];
  logic [DATA_W-1:0]   lbp_mem  [NumPix];
  logic [NumPix-1:0]   written_q;

  logic [RowW-1:0]     row;
  logic [ColW-1:0]     col;
  logic                is_border;
  logic                capture;
  logic                is_dup;
  logic                load_wr;
  logic                mem_wr;
  logic                new_wr;
  logic [ADDR_W:0]     eff_count;

  assign row       = lbp_addr[ADDR_W-1:ColW];
  assign col       = lbp_addr[ColW-1:0];
  assign is_border = (row == '0) || (row == RowLast) || (col == '0) || (col == ColLast);
  assign capture   = lbp_valid && (state_q != StLoad);
  assign is_dup    = written_q[lbp_addr];
  assign mem_wr    = capture && !is_border;
  assign new_wr    = mem_wr && !is_dup;
  assign load_wr   = load_valid && (state_q == StLoad);
  // Count as it will stand after this edge, so a finish coincident with the last write passes.
  assign eff_count = {1'b0, wr_count_q} + {{ADDR_W{1'b0}}, new_wr};

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gray_ready_d = gray_ready_q;
    done_d       = done_q;
    err_border_d = err_border_q || (capture && is_border);
    err_dup_d    = err_dup_q || (mem_wr && is_dup);
    err_early_d  = err_early_q;
    wr_count_d   = (new_wr && (wr_count_q != '1)) ? wr_count_q + 1'b1 : wr_count_q;
    unique case (state_q)
      StLoad: begin
        if (load_valid) begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == LastPix) begin
            state_d      = StServe;
            gray_ready_d = 1'b1;
          end
        end
      end
      StServe: begin
        if (finish) begin
          if (eff_count < InteriorCnt) begin
            err_early_d = 1'b1;
          end else if (eff_count == InteriorCnt) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StDone: begin
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StLoad;
      ptr_q        <= '0;
      wr_count_q   <= '0;
      gray_ready_q <= 1'b0;
      done_q       <= 1'b0;
      err_border_q <= 1'b0;
      err_dup_q    <= 1'b0;
      err_early_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wr_count_q   <= wr_count_d;
      gray_ready_q <= gray_ready_d;
      done_q       <= done_d;
      err_border_q <= err_border_d;
      err_dup_q    <= err_dup_d;
      err_early_q  <= err_early_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      written_q <= '0;
    end else if (new_wr) begin
      written_q[lbp_addr] <= 1'b1;
    end
  end

  // Image and result storage survive reset.
  always_ff @(posedge clk) begin
    if (reset && load_wr) begin
      gray_mem[ptr_q] <= load_data;
    end
    if (reset && mem_wr) begin
      lbp_mem[lbp_addr] <= lbp_data;
    end
  end

  always_comb begin
    gray_data = '0;
    if (gray_req && gray_ready_q) begin
      gray_data = gray_mem[gray_addr];
    end
  end

  assign rd_data    = lbp_mem[rd_addr];
  assign gray_ready = gray_ready_q;
  assign wr_count   = wr_count_q;
  assign done       = done_q;
  assign err_border = err_border_q;
  assign err_dup    = err_dup_q;
  assign err_early  = err_early_q;

endmodule
